// File: rtl/sram_responder.sv
// Cycle-based model of an asynchronous 16-bit SRAM on a shared tristate bus.
// Initiator accesses have priority; a side preload port fills memory while the chip is deselected.
module sram_responder #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  input  logic        Load_Valid,
  input  logic [19:0] Load_Addr,
  input  logic [15:0] Load_Data,
  output logic        Load_Ready,
  output logic [15:0] Rd_Count,
  output logic [15:0] Wr_Count
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] mem [WORDS];
  logic [15:0] rd_q;

  logic is_write;
  logic is_read;
  logic is_load;
  logic addr_ok;
  logic load_addr_ok;
  logic any_lane;

  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] load_idx;

  assign idx          = ADDR[DEPTH_LOG2-1:0];
  assign load_idx     = Load_Addr[DEPTH_LOG2-1:0];
  assign addr_ok      = (ADDR >> DEPTH_LOG2) == 20'd0;
  assign load_addr_ok = (Load_Addr >> DEPTH_LOG2) == 20'd0;

  // Deselecting the chip is what frees the array for preloading.
  assign Load_Ready = Reset & CE;

  assign is_write = ~CE & ~WE;
  assign is_read  = ~CE &  WE & ~OE;
  assign is_load  =  CE & Load_Valid & Load_Ready;
  assign any_lane = ~UB | ~LB;

  always_comb begin
    state_next = IDLE;
    if (is_write)     state_next = WR;
    else if (is_read) state_next = RD;
    else if (is_load) state_next = LOAD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)       rd_q <= 16'h0000;
    else if (is_read) rd_q <= addr_ok ? mem[idx] : 16'h0000;
  end

  // NOTE: the array has no reset branch; contents must survive reset, and a reset would force it into flops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (is_write && addr_ok) begin
        if (!UB) mem[idx][15:8] <= Data[15:8];
        if (!LB) mem[idx][7:0]  <= Data[7:0];
      end else if (is_load && load_addr_ok) begin
        mem[load_idx] <= Load_Data;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Rd_Count <= 16'h0000;
      Wr_Count <= 16'h0000;
    end else begin
      if (is_read && Rd_Count != 16'hFFFF)
        Rd_Count <= Rd_Count + 16'd1;
      if (is_write && any_lane && Wr_Count != 16'hFFFF)
        Wr_Count <= Wr_Count + 16'd1;
    end
  end

  // Released as soon as the current strobes stop being a read, so a falling WE never contends.
  assign Data = (state == RD && is_read) ? rd_q : {16{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded bench for sram_responder: stimulus pushes per-cycle expectations from a
// word-array reference model; a negedge monitor pops and compares bus, Load_Ready and counters.
module tb_sram_responder;

  typedef struct {
    logic [15:0] bus;
    logic        lr;
    logic [15:0] rc;
    logic [15:0] wc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        CE = 1'b1;
  logic        UB = 1'b1;
  logic        LB = 1'b1;
  logic        OE = 1'b1;
  logic        WE = 1'b1;
  logic [19:0] ADDR = '0;
  logic        Load_Valid = 1'b0;
  logic [19:0] Load_Addr = '0;
  logic [15:0] Load_Data = '0;
  logic        Load_Ready;
  logic [15:0] Rd_Count;
  logic [15:0] Wr_Count;
  wire  [15:0] Data;

  // The bench owns the bus whenever the responder should not drive it, using a fresh
  // random word each cycle, so a wrongly driven or wrongly released bus shows up as a bad value.
  logic        tb_drv = 1'b1;
  logic [15:0] tb_val = '0;
  assign Data = tb_drv ? tb_val : {16{1'bz}};

  sram_responder #(.DEPTH_LOG2(10)) dut (
    .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .ADDR(ADDR), .Data(Data), .Load_Valid(Load_Valid), .Load_Addr(Load_Addr),
    .Load_Data(Load_Data), .Load_Ready(Load_Ready), .Rd_Count(Rd_Count), .Wr_Count(Wr_Count)
  );

  initial forever #5 Clk = ~Clk;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  logic [15:0] m_mem [0:1023];
  logic        m_prev_rd = 1'b0;
  logic [15:0] m_rd_val = '0;
  int          m_rc = 0;
  int          m_wc = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic in_rng(input logic [19:0] a);
    return a < 20'd1024;
  endfunction

  // One bus cycle: inputs applied just after a rising edge, expectations queued, model advanced by the edge.
  task automatic cycle(input logic rst, input logic ce, input logic we, input logic oe,
                       input logic ub, input logic lb, input logic [19:0] addr,
                       input logic [15:0] wdata, input logic lv, input logic [19:0] la,
                       input logic [15:0] ld);
    exp_t e;
    logic rd_now;
    logic dut_drv;
    Reset = rst; CE = ce; WE = we; OE = oe; UB = ub; LB = lb; ADDR = addr;
    Load_Valid = lv; Load_Addr = la; Load_Data = ld;
    if (!rst) begin
      m_rc = 0;
      m_wc = 0;
      m_prev_rd = 1'b0;
    end
    rd_now  = !ce && we && !oe;
    dut_drv = rst && m_prev_rd && rd_now;
    tb_val  = !we ? wdata : 16'($urandom);
    tb_drv  = !dut_drv;
    e.bus = dut_drv ? m_rd_val : tb_val;
    e.lr  = rst && ce;
    e.rc  = 16'(m_rc);
    e.wc  = 16'(m_wc);
    exp_q.push_back(e);
    @(posedge Clk);
    if (rst) begin
      if (!ce && !we) begin
        m_prev_rd = 1'b0;
        if ((!ub || !lb) && m_wc < 65535) m_wc++;
        if (in_rng(addr)) begin
          if (!ub) m_mem[addr[9:0]][15:8] = wdata[15:8];
          if (!lb) m_mem[addr[9:0]][7:0]  = wdata[7:0];
        end
      end else if (rd_now) begin
        m_prev_rd = 1'b1;
        m_rd_val  = in_rng(addr) ? m_mem[addr[9:0]] : 16'h0000;
        if (m_rc < 65535) m_rc++;
      end else begin
        m_prev_rd = 1'b0;
        if (ce && lv && in_rng(la)) m_mem[la[9:0]] = ld;
      end
    end
    #1;
  endtask

  task automatic idle(input logic rst);
    cycle(rst, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 16'h0, 1'b0, 20'h0, 16'h0);
  endtask

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 16'h0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [19:0] a);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, a, 16'h0, 1'b0, 20'h0, 16'h0);
  endtask

  task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, ub, lb, a, d, 1'b0, 20'h0, 16'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_bus", Data, e.bus);
        check("load_ready", {15'b0, Load_Ready}, {15'b0, e.lr});
        check("rd_count", Rd_Count, e.rc);
        check("wr_count", Wr_Count, e.wc);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (2) @(posedge Clk);
    #1;
    repeat (3) idle(1'b0);
    idle(1'b1);

    // Fill the working window so every later in-range read has a known value.
    for (int i = 0; i < 32; i++) begin
      if (i == 5)       preload(20'(i), 16'h1234);
      else if (i == 16) preload(20'(i), 16'h0000);
      else              preload(20'(i), 16'($urandom));
    end

    // Preload is refused while the chip is selected, accepted once CE returns high.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 16'h0, 1'b1, 20'h0, 16'hBEEF);
    rd(20'h0); rd(20'h0);
    preload(20'h0, 16'hBEEF);
    rd(20'h0); rd(20'h0);
    idle(1'b1);

    // Preloaded word readable one cycle after the read begins; address change follows a cycle later.
    rd(20'h5); rd(20'h5); rd(20'h6); rd(20'h6);
    idle(1'b1);

    // Upper-lane-only write over zero, then read back.
    wr(20'h10, 16'hABCD, 1'b0, 1'b1);
    rd(20'h10); rd(20'h10);

    // WE falling during a read: bus released that cycle, write lands at the next edge.
    wr(20'h10, 16'h1357, 1'b0, 1'b0);
    rd(20'h10); rd(20'h10);
    idle(1'b1);

    // Out-of-range read returns zero; out-of-range write leaves aliased location alone.
    rd(20'h80000); rd(20'h80000);
    wr(20'h80000, 16'hFFFF, 1'b0, 1'b0);
    rd(20'h0); rd(20'h0);

    // No lanes enabled: nothing stored, nothing counted.
    wr(20'h1, 16'h5555, 1'b1, 1'b1);
    rd(20'h1); rd(20'h1);

    // Reset during a read releases the bus and clears counters; memory survives.
    rd(20'h5); rd(20'h5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h5, 16'h0, 1'b0, 20'h0, 16'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h5, 16'h0, 1'b0, 20'h0, 16'h0);
    rd(20'h5); rd(20'h5); rd(20'h0);

    // Randomized traffic, including preloads, out-of-range addresses and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [19:0] a;
      logic [19:0] la;
      a  = ($urandom_range(7) == 0) ? (20'h400 | 20'($urandom)) : 20'($urandom_range(31));
      la = ($urandom_range(7) == 0) ? (20'h400 | 20'($urandom)) : 20'($urandom_range(31));
      cycle(($urandom_range(99) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), a, 16'($urandom), 1'($urandom), la, 16'($urandom));
    end

    // Read counter saturation, then a write still counts.
    idle(1'b0);
    for (int i = 0; i < 65540; i++) rd(20'h1);
    wr(20'h2, 16'h2468, 1'b0, 1'b0);
    rd(20'h2); rd(20'h2);
    idle(1'b1);

    repeat (2) @(negedge Clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
